// File: rtl/romulator_pkg.sv
// Shared romulator definitions: enable-table geometry and the loader state encoding.
package romulator_pkg;
  localparam int NUM_ENTRIES      = 512;
  localparam int ENTRIES_PER_BYTE = 4;
  localparam int TBL_ADDR_W       = 9;
  localparam int ENTRY_W          = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } etl_state_t;
endpackage

// File: rtl/enable_table_loader.sv
// Streams packed 2-bit enable entries from a byte source into the enable table,
// one entry per cycle, with abort and a one-cycle done pulse.
module enable_table_loader #(
  parameter int NUM_ENTRIES      = romulator_pkg::NUM_ENTRIES,
  parameter int ENTRIES_PER_BYTE = romulator_pkg::ENTRIES_PER_BYTE
) (
  input  logic                                fpga_clk,
  input  logic                                resetn,
  input  logic                                start,
  input  logic                                abort,
  input  logic [7:0]                          byte_data,
  input  logic                                byte_valid,
  output logic                                byte_ready,
  output logic                                table_we,
  output logic [romulator_pkg::ENTRY_W-1:0]    table_val,
  output logic [romulator_pkg::TBL_ADDR_W-1:0] table_write_addr,
  output logic                                busy,
  output logic                                done
);
  import romulator_pkg::*;

  localparam int SUB_W = (ENTRIES_PER_BYTE > 1) ? $clog2(ENTRIES_PER_BYTE) : 1;

  etl_state_t            state;
  logic [TBL_ADDR_W-1:0] cnt;
  logic [SUB_W-1:0]      sub;
  logic [SUB_W-1:0]      sub_nx;
  logic [7:0]            byte_q;
  logic                  last_sub;
  logic                  last_ent;

  assign sub_nx   = sub + SUB_W'(1);
  assign last_sub = (sub == SUB_W'(ENTRIES_PER_BYTE - 1));
  assign last_ent = (cnt == TBL_ADDR_W'(NUM_ENTRIES - 1));

  function automatic logic [ENTRY_W-1:0] pick(input logic [7:0] b, input logic [SUB_W-1:0] k);
    pick = b[ENTRY_W*k +: ENTRY_W];
  endfunction

  // Outputs are registered one step ahead: the cycle that shows table_we=1 already
  // carries the value/address for the current sub-index.
  always_ff @(posedge fpga_clk or negedge resetn) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      sub              <= '0;
      byte_q           <= '0;
      table_we         <= 1'b0;
      table_val        <= '0;
      table_write_addr <= '0;
      byte_ready       <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      table_we <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state      <= ST_FETCH;
            cnt        <= '0;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (abort) begin
            state      <= ST_IDLE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
          end else if (byte_valid) begin
            state            <= ST_WRITE;
            byte_q           <= byte_data;
            sub              <= '0;
            byte_ready       <= 1'b0;
            table_we         <= 1'b1;
            table_val        <= byte_data[ENTRY_W-1:0];
            table_write_addr <= cnt;
          end
        end
        ST_WRITE: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + TBL_ADDR_W'(1);
            sub <= sub_nx;
            if (last_sub) begin
              if (last_ent) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state      <= ST_FETCH;
                byte_ready <= 1'b1;
              end
            end else begin
              table_we         <= 1'b1;
              table_val        <= pick(byte_q, sub_nx);
              table_write_addr <= cnt + TBL_ADDR_W'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
